// File: rtl/shift_out_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_out_register_pkg
// Shared definitions for the parallel-in / serial-out transmitter:
//   - 2-bit state encoding for the IDLE / SHIFT / LATCH controller
//   - constant functions that validate the WIDTH and DIV parameters. They are
//     evaluated during elaboration so an illegal configuration stops the build.
// -----------------------------------------------------------------------------
package shift_out_register_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_LATCH_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_LATCH = ST_LATCH_ENC
  } state_t;

  // sclk is high for exactly half of each bit, so DIV must split evenly.
  function automatic bit div_is_even(input int div);
    return (div % 2) == 0;
  endfunction

  // One low clock and one high clock is the fastest legal serial bit.
  function automatic bit div_is_min(input int div);
    return div >= 2;
  endfunction

  // The shifter slices one bit below the top, so at least two bits are needed.
  function automatic bit width_is_min(input int width);
    return width >= 2;
  endfunction

endpackage

// File: rtl/shift_out_register_if.sv
// -----------------------------------------------------------------------------
// shift_out_register_if
// Bus bundle between the requester and the serial transmitter.
//   D      parallel word to transmit (requester -> transmitter)
//   start  transfer request          (requester -> transmitter)
//   ready  transmitter idle          (transmitter -> requester)
//   sclk   serial clock, idle low    (transmitter -> peripheral)
//   sdata  serial data               (transmitter -> peripheral)
//   latch  latch strobe after word   (transmitter -> peripheral)
//   done   one-cycle completion pulse(transmitter -> requester)
// Modports: master = requester side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface shift_out_register_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] D;
  logic             start;
  logic             ready;
  logic             sclk;
  logic             sdata;
  logic             latch;
  logic             done;

  modport master (
    output D,
    output start,
    input  ready,
    input  sclk,
    input  sdata,
    input  latch,
    input  done
  );

  modport slave (
    input  D,
    input  start,
    output ready,
    output sclk,
    output sdata,
    output latch,
    output done
  );

endinterface

// File: rtl/shift_out_register_bit_timer.sv
// -----------------------------------------------------------------------------
// shift_bit_timer
// Divider counter that paces one serial bit over DIV system clocks.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset, clears the count
//   enable     advance the count this clock
//   clear      force the count back to 0 (wins over enable)
//   half_tick  count is at DIV/2-1 while enabled: sclk rises on the next edge
//   bit_tick   count is at DIV-1 while enabled: bit period ends on the next edge
// -----------------------------------------------------------------------------
module shift_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic half_tick,
  output logic bit_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Divider count; explicitly returned to 0 at its terminal value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == BIT_LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end else begin
      count <= count;
    end
  end

  // Tick decode from the current count.
  always_comb begin
    half_tick = 1'b0;
    bit_tick  = 1'b0;
    if (enable && !clear) begin
      half_tick = (count == HALF_LAST);
      bit_tick  = (count == BIT_LAST);
    end else begin
      half_tick = 1'b0;
      bit_tick  = 1'b0;
    end
  end

endmodule

// File: rtl/shift_out_register.sv
// -----------------------------------------------------------------------------
// shift_out_register
// Parallel-in, serial-out transmitter. A word captured on an accepted start is
// sent on sclk/sdata (DIV system clocks per bit, sclk low then high), followed
// by a DIV-clock latch strobe and a one-cycle done pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-low reset
//   bus    shift_out_register_if.slave: D, start in; ready, sclk, sdata,
//          latch, done out (all outputs registered)
// Parameters: WIDTH bits per word, DIV clocks per bit, MSB_FIRST bit order.
// -----------------------------------------------------------------------------
module shift_out_register
  import shift_out_register_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_out_register_if.slave    bus
);

  if (!div_is_even(DIV)) begin : g_chk_div_even
    $error("shift_out_register: DIV must be even");
  end
  if (!div_is_min(DIV)) begin : g_chk_div_min
    $error("shift_out_register: DIV must be >= 2");
  end
  if (!width_is_min(WIDTH)) begin : g_chk_width_min
    $error("shift_out_register: WIDTH must be >= 2");
  end

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] BIT_CNT_LAST = BCW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic             ready;
  logic             sclk;
  logic             sdata;
  logic             latch;
  logic             done;

  logic             accept;
  logic             timer_enable;
  logic             half_tick;
  logic             bit_tick;
  logic [WIDTH-1:0] shreg_next;
  logic             next_bit;

  assign accept       = (state == ST_IDLE) && bus.start;
  assign timer_enable = (state != ST_IDLE);

  shift_bit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (timer_enable),
    .clear     (accept),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  // Shifted word and the bit that becomes visible on sdata after a shift.
  always_comb begin
    shreg_next = '0;
    next_bit   = 1'b0;
    if (MSB_FIRST) begin
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
      next_bit   = shreg[WIDTH-2];
    end else begin
      shreg_next = {1'b0, shreg[WIDTH-1:1]};
      next_bit   = shreg[1];
    end
  end

  // Transfer controller, shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      ready   <= 1'b1;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      latch   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            shreg   <= bus.D;
            bit_cnt <= '0;
            // First bit is driven immediately so it is valid for the whole
            // first bit period.
            sdata   <= MSB_FIRST ? bus.D[WIDTH-1] : bus.D[0];
            ready   <= 1'b0;
            state   <= ST_SHIFT;
          end else begin
            ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (half_tick) begin
            sclk <= 1'b1;
          end else if (bit_tick) begin
            sclk  <= 1'b0;
            shreg <= shreg_next;
            if (bit_cnt == BIT_CNT_LAST) begin
              bit_cnt <= '0;
              sdata   <= 1'b0;
              latch   <= 1'b1;
              state   <= ST_LATCH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sdata   <= next_bit;
            end
          end else begin
            sclk <= sclk;
          end
        end
        ST_LATCH: begin
          // The divider keeps running here to time the DIV-clock strobe.
          if (bit_tick) begin
            latch <= 1'b0;
            done  <= 1'b1;
            ready <= 1'b1;
            state <= ST_IDLE;
          end else begin
            latch <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          shreg   <= '0;
          bit_cnt <= '0;
          ready   <= 1'b1;
          sclk    <= 1'b0;
          sdata   <= 1'b0;
          latch   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready;
  assign bus.sclk  = sclk;
  assign bus.sdata = sdata;
  assign bus.latch = latch;
  assign bus.done  = done;

endmodule

// File: tb/tb_shift_out_register.sv
// -----------------------------------------------------------------------------
// tb_shift_out_register
// Directed bench for shift_out_register with three configurations:
//   dut_a WIDTH=8  DIV=4 MSB_FIRST=1
//   dut_b WIDTH=8  DIV=4 MSB_FIRST=0
//   dut_c WIDTH=32 DIV=2 MSB_FIRST=1
// Cycle c is the clock period after edge c-1, with start accepted at edge 0.
// -----------------------------------------------------------------------------
module tb_shift_out_register;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  shift_out_register_if #(.WIDTH(8))  bus_a ();
  shift_out_register_if #(.WIDTH(8))  bus_b ();
  shift_out_register_if #(.WIDTH(32)) bus_c ();

  shift_out_register #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut_a (
    .clk (clk), .reset (reset), .bus (bus_a)
  );
  shift_out_register #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) dut_b (
    .clk (clk), .reset (reset), .bus (bus_b)
  );
  shift_out_register #(.WIDTH(32), .DIV(2), .MSB_FIRST(1'b1)) dut_c (
    .clk (clk), .reset (reset), .bus (bus_c)
  );

  int errors = 0;
  int checks = 0;
  int sel    = 0;

  logic o_ready, o_sclk, o_sdata, o_latch, o_done;

  // Route the selected instance's outputs to the observation signals.
  always_comb begin
    case (sel)
      1: begin
        o_ready = bus_b.ready; o_sclk = bus_b.sclk; o_sdata = bus_b.sdata;
        o_latch = bus_b.latch; o_done = bus_b.done;
      end
      2: begin
        o_ready = bus_c.ready; o_sclk = bus_c.sclk; o_sdata = bus_c.sdata;
        o_latch = bus_c.latch; o_done = bus_c.done;
      end
      default: begin
        o_ready = bus_a.ready; o_sclk = bus_a.sclk; o_sdata = bus_a.sdata;
        o_latch = bus_a.latch; o_done = bus_a.done;
      end
    endcase
  end

  task automatic drive(input int s, input logic [31:0] d, input logic st);
    case (s)
      1:       begin bus_b.D = d[7:0]; bus_b.start = st; end
      2:       begin bus_c.D = d;      bus_c.start = st; end
      default: begin bus_a.D = d[7:0]; bus_a.start = st; end
    endcase
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full transfer on instance s. Starts at #1 after an edge, returns in
  // the done cycle (cycle WIDTH*DIV+DIV+1) with start left as hold_start.
  task automatic run_transfer(input int s, input int width, input int div,
                              input logic [31:0] d, input logic [31:0] exp_bits,
                              input bit hold_start, input int stray_cyc,
                              input bit use_mid, input logic [31:0] mid_d,
                              input string name);
    int wd, last, n_pulse, done_cyc, n_done;
    int sclk_bad, latch_bad, ready_bad, stable_bad, sdata_bad;
    logic [31:0] got, cur_d;
    logic prev_sclk, prev_sdata, exp_sclk, exp_latch, exp_ready, cur_st;
    wd = width * div;
    last = wd + div + 1;
    n_pulse = 0; done_cyc = 0; n_done = 0;
    sclk_bad = 0; latch_bad = 0; ready_bad = 0; stable_bad = 0; sdata_bad = 0;
    got = 32'h0; prev_sclk = 1'b0; prev_sdata = 1'b0;

    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_start: got %b want 1", name, o_ready);
    end
    drive(s, d, 1'b1);

    for (int c = 1; c <= last; c++) begin
      next_cycle();
      exp_sclk  = (c <= wd) ? (((c - 1) % div) >= (div / 2)) : 1'b0;
      exp_latch = (c > wd) && (c <= wd + div);
      exp_ready = (c == last);
      if (o_sclk !== exp_sclk) sclk_bad++;
      if (o_latch !== exp_latch) latch_bad++;
      if (o_ready !== exp_ready) ready_bad++;
      if ((c > wd) && (o_sdata !== 1'b0)) sdata_bad++;
      if ((o_sclk === 1'b1) && (prev_sclk === 1'b1) && (o_sdata !== prev_sdata)) stable_bad++;
      if ((o_sclk === 1'b1) && (prev_sclk === 1'b0)) begin
        if (n_pulse < 32) got[n_pulse] = o_sdata;
        n_pulse++;
      end
      if (o_done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      prev_sclk  = o_sclk;
      prev_sdata = o_sdata;
      cur_d  = (use_mid && (c >= wd / 2)) ? mid_d : d;
      cur_st = (c < last) ? (hold_start || (c == stray_cyc)) : hold_start;
      drive(s, cur_d, cur_st);
    end

    checks++;
    if (got !== exp_bits) begin
      errors++; $display("FAIL %s sampled_bits: got %h want %h", name, got, exp_bits);
    end
    checks++;
    if (n_pulse != width) begin
      errors++; $display("FAIL %s sclk_pulses: got %0d want %0d", name, n_pulse, width);
    end
    checks++;
    if (sclk_bad != 0) begin
      errors++; $display("FAIL %s sclk_waveform: got %0d bad cycles want 0", name, sclk_bad);
    end
    checks++;
    if (stable_bad != 0) begin
      errors++; $display("FAIL %s sdata_stable_high: got %0d changes want 0", name, stable_bad);
    end
    checks++;
    if (latch_bad != 0) begin
      errors++; $display("FAIL %s latch_window: got %0d bad cycles want 0", name, latch_bad);
    end
    checks++;
    if (ready_bad != 0) begin
      errors++; $display("FAIL %s ready_window: got %0d bad cycles want 0", name, ready_bad);
    end
    checks++;
    if (sdata_bad != 0) begin
      errors++; $display("FAIL %s sdata_after_word: got %0d bad cycles want 0", name, sdata_bad);
    end
    checks++;
    if (done_cyc != last) begin
      errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, last);
    end
    checks++;
    if (n_done != 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d want 1", name, n_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 32'h0, 1'b0); drive(1, 32'h0, 1'b0); drive(2, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({o_ready, o_sclk, o_sdata, o_latch, o_done} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_values inst%0d: got rdy/sclk/sdata/latch/done=%b want 10000",
                 s, {o_ready, o_sclk, o_sdata, o_latch, o_done});
      end
    end
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_msb_first();
    sel = 0; next_cycle();
    // A5 = 1010_0101 MSB first -> 1,0,1,0,0,1,0,1 (bit i = i-th sample)
    run_transfer(0, 8, 4, 32'hA5, 32'hA5, 1'b0, 0, 1'b0, 32'h0, "msb_a5");
    repeat (3) next_cycle();
    // 96 = 1001_0110 MSB first -> 1,0,0,1,0,1,1,0 -> 0x69
    run_transfer(0, 8, 4, 32'h96, 32'h69, 1'b0, 0, 1'b0, 32'h0, "msb_96");
    repeat (3) next_cycle();
  endtask

  task automatic test_lsb_first();
    sel = 1; next_cycle();
    // A5 LSB first -> 1,0,1,0,0,1,0,1 (palindrome)
    run_transfer(1, 8, 4, 32'hA5, 32'hA5, 1'b0, 0, 1'b0, 32'h0, "lsb_a5");
    repeat (2) next_cycle();
    // 01 LSB first -> first sample 1, remaining seven 0
    run_transfer(1, 8, 4, 32'h01, 32'h01, 1'b0, 0, 1'b0, 32'h0, "lsb_01");
    repeat (2) next_cycle();
    // 96 LSB first -> 0,1,1,0,1,0,0,1 -> 0x96
    run_transfer(1, 8, 4, 32'h96, 32'h96, 1'b0, 0, 1'b0, 32'h0, "lsb_96");
    repeat (3) next_cycle();
  endtask

  task automatic test_back_to_back();
    sel = 0; next_cycle();
    // start held high; D moves to 00 mid-word and must not disturb FF
    run_transfer(0, 8, 4, 32'hFF, 32'hFF, 1'b1, 0, 1'b1, 32'h00, "b2b_ff");
    run_transfer(0, 8, 4, 32'h00, 32'h00, 1'b0, 0, 1'b0, 32'h0, "b2b_00");
    repeat (3) next_cycle();
  endtask

  task automatic test_stray_start();
    int idle_bad;
    sel = 0; next_cycle();
    run_transfer(0, 8, 4, 32'h96, 32'h69, 1'b0, 10, 1'b0, 32'h0, "stray_start");
    idle_bad = 0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      if ((o_ready !== 1'b1) || (o_sclk !== 1'b0) || (o_done !== 1'b0)) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin
      errors++; $display("FAIL stray_start_queued: got %0d busy cycles want 0", idle_bad);
    end
  endtask

  task automatic test_reset_mid();
    int after_bad;
    sel = 0; next_cycle();
    drive(0, 32'hFF, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      next_cycle();
      drive(0, 32'hFF, 1'b0);
    end
    // cycle 15: bit 3, sclk high, sdata 1
    checks++;
    if ({o_sclk, o_sdata} !== 2'b11) begin
      errors++; $display("FAIL reset_mid_precondition: got sclk/sdata=%b want 11", {o_sclk, o_sdata});
    end
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    checks++;
    if ({o_ready, o_sclk, o_sdata, o_latch, o_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid_values: got rdy/sclk/sdata/latch/done=%b want 10000",
               {o_ready, o_sclk, o_sdata, o_latch, o_done});
    end
    after_bad = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      if ((o_latch !== 1'b0) || (o_done !== 1'b0) || (o_sclk !== 1'b0) || (o_ready !== 1'b1)) after_bad++;
    end
    checks++;
    if (after_bad != 0) begin
      errors++; $display("FAIL reset_mid_abandon: got %0d active cycles want 0", after_bad);
    end
    run_transfer(0, 8, 4, 32'hA5, 32'hA5, 1'b0, 0, 1'b0, 32'h0, "after_reset_a5");
    repeat (3) next_cycle();
  endtask

  task automatic test_wide();
    sel = 2; next_cycle();
    // 32 bits at DIV=2, first and last sampled bits 1, done at cycle 67
    run_transfer(2, 32, 2, 32'h8000_0001, 32'h8000_0001, 1'b0, 0, 1'b0, 32'h0, "wide_80000001");
    repeat (3) next_cycle();
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stray_start();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
